// File: rtl/param_reporter_pkg.sv
// Shared encodings and ASCII constants for the parameter report path.
package param_reporter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV_H,
        ST_CONV_T,
        ST_BUILD,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_HUND,
        CV_TENS
    } conv_phase_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [2:0] ERR_LEN    = 3'd5;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/param_reporter_if.sv
// Request side (settings logic) and byte side (uart_tx) of the reporter.
interface param_reporter_if;
    logic       report_req;
    logic       report_error;
    logic [7:0] param_value;
    logic       busy;
    logic       report_done;
    logic       report_timeout;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_done;

    modport master (
        output report_req, report_error, param_value, uart_tx_done,
        input  busy, report_done, report_timeout, uart_tx_en, uart_tx_data
    );

    modport slave (
        input  report_req, report_error, param_value, uart_tx_done,
        output busy, report_done, report_timeout, uart_tx_en, uart_tx_data
    );
endinterface

// File: rtl/param_reporter_bin8_to_dec.sv
// Sequential 8-bit binary to decimal converter by repeated subtraction.
module bin8_to_dec
    import param_reporter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    output logic       hund_done,
    output logic       done,
    output logic [1:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_phase_t phase_q, phase_n;
    logic [7:0]  rem_q;
    logic [1:0]  hund_q;
    logic [3:0]  tens_q;

    // Both phase-exit flags are combinational so the parent FSM steps in lockstep.
    always_comb begin
        phase_n   = phase_q;
        hund_done = (phase_q == CV_HUND) && (rem_q < 8'd100);
        done      = (phase_q == CV_TENS) && (rem_q < 8'd10);
        case (phase_q)
            CV_IDLE: if (start)     phase_n = CV_HUND;
            CV_HUND: if (hund_done) phase_n = CV_TENS;
            CV_TENS: if (done)      phase_n = CV_IDLE;
            default:                phase_n = CV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= CV_IDLE;
            rem_q   <= 8'h00;
            hund_q  <= 2'd0;
            tens_q  <= 4'd0;
        end else begin
            phase_q <= phase_n;
            if (start && phase_q == CV_IDLE) begin
                rem_q  <= value;
                hund_q <= 2'd0;
                tens_q <= 4'd0;
            end else if (phase_q == CV_HUND && !hund_done) begin
                rem_q  <= rem_q - 8'd100;
                hund_q <= hund_q + 2'd1;
            end else if (phase_q == CV_TENS && !done) begin
                rem_q  <= rem_q - 8'd10;
                tens_q <= tens_q + 4'd1;
            end
        end
    end

    assign hund = hund_q;
    assign tens = tens_q;
    assign ones = rem_q[3:0];

endmodule

// File: rtl/param_reporter.sv
// Streams a parameter value as ASCII decimal + CR LF (or "ERR" CR LF) to uart_tx.
module param_reporter
    import param_reporter_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int TX_TIMEOUT_CNT = CLK_FREQ / 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    param_reporter_if.slave  bus
);

    localparam int            TW      = $clog2(TX_TIMEOUT_CNT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TX_TIMEOUT_CNT - 1);

    state_t          state_q, state_n;
    logic [4:0][7:0] buf_q;
    logic [2:0]      len_q;
    logic [2:0]      idx_q;
    logic [TW-1:0]   to_cnt_q;

    logic            busy_q, tx_en_q, done_q, timeout_q;
    logic [7:0]      tx_data_q;

    logic            conv_start, conv_hund_done, conv_done;
    logic [1:0]      conv_hund;
    logic [3:0]      conv_tens, conv_ones;
    logic            load_err, build, send, advance, timeout;

    bin8_to_dec u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (conv_start),
        .value     (bus.param_value),
        .hund_done (conv_hund_done),
        .done      (conv_done),
        .hund      (conv_hund),
        .tens      (conv_tens),
        .ones      (conv_ones)
    );

    always_comb begin
        state_n    = state_q;
        conv_start = 1'b0;
        load_err   = 1'b0;
        build      = 1'b0;
        send       = 1'b0;
        advance    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.report_req) begin
                    if (bus.report_error) begin
                        load_err = 1'b1;
                        state_n  = ST_LOAD;
                    end else begin
                        conv_start = 1'b1;
                        state_n    = ST_CONV_H;
                    end
                end
            end
            ST_CONV_H: if (conv_hund_done) state_n = ST_CONV_T;
            ST_CONV_T: if (conv_done)      state_n = ST_BUILD;
            ST_BUILD: begin
                build   = 1'b1;
                state_n = ST_LOAD;
            end
            ST_LOAD: begin
                send    = 1'b1;
                state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done on the last allowed cycle still wins over the timeout.
                if (bus.uart_tx_done) begin
                    advance = 1'b1;
                    state_n = (idx_q == len_q - 3'd1) ? ST_FINISH : ST_LOAD;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
            to_cnt_q  <= '0;
            busy_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_n;
            busy_q    <= (state_n != ST_IDLE);
            tx_en_q   <= send;
            done_q    <= (state_n == ST_FINISH);
            timeout_q <= timeout;

            if (load_err) begin
                buf_q <= {ASCII_LF, ASCII_CR, ASCII_R, ASCII_R, ASCII_E};
                len_q <= ERR_LEN;
                idx_q <= 3'd0;
            end

            // Leading zeros are suppressed by shifting the frame down to slot 0.
            if (build) begin
                idx_q <= 3'd0;
                if (conv_hund != 2'd0) begin
                    buf_q <= {ASCII_LF, ASCII_CR, ascii_digit(conv_ones),
                              ascii_digit(conv_tens), ascii_digit({2'b00, conv_hund})};
                    len_q <= 3'd5;
                end else if (conv_tens != 4'd0) begin
                    buf_q <= {8'h00, ASCII_LF, ASCII_CR, ascii_digit(conv_ones),
                              ascii_digit(conv_tens)};
                    len_q <= 3'd4;
                end else begin
                    buf_q <= {8'h00, 8'h00, ASCII_LF, ASCII_CR, ascii_digit(conv_ones)};
                    len_q <= 3'd3;
                end
            end

            if (send) begin
                tx_data_q <= buf_q[idx_q];
                to_cnt_q  <= '0;
            end else if (state_q == ST_WAIT_DONE) begin
                to_cnt_q  <= to_cnt_q + TW'(1);
            end

            if (advance) idx_q <= idx_q + 3'd1;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.uart_tx_en     = tx_en_q;
    assign bus.uart_tx_data   = tx_data_q;
    assign bus.report_done    = done_q;
    assign bus.report_timeout = timeout_q;

endmodule

// File: tb/tb_param_reporter.sv
// Directed bench for param_reporter with an inline uart_tx done responder.
module tb_param_reporter;
    localparam int CLK_FREQ = 50_000;
    localparam int TO       = CLK_FREQ / 1000;
    localparam int DLY      = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    param_reporter_if bus();

    param_reporter #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] got[8];
    int         en_cyc[8];
    int         nb, done_at, to_at, last_ack;
    bit         stable_ok;

    // Cycle numbering: request is accepted at the end of cycle 0.
    task automatic send_req(input logic [7:0] v, input logic err);
        @(negedge clk);
        bus.report_req   = 1'b1;
        bus.param_value  = v;
        bus.report_error = err;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_accept: got %b want 1", bus.busy);
        end
        bus.report_req   = 1'b0;
        bus.param_value  = 8'hA5;
        bus.report_error = ~err;
    endtask

    task automatic capture(input int ack_limit, input int inject_at, input int budget);
        bit         pend;
        int         due;
        logic [7:0] cur;
        nb = 0; done_at = -1; to_at = -1; last_ack = -1; stable_ok = 1'b1;
        pend = 1'b0; due = 0; cur = 8'h00;
        for (int c = 2; c < budget; c++) begin
            @(negedge clk);
            bus.uart_tx_done = 1'b0;
            bus.report_req   = 1'b0;
            if (c == inject_at) begin
                bus.report_req   = 1'b1;
                bus.param_value  = 8'd7;
                bus.report_error = 1'b0;
            end
            if (pend) begin
                if (bus.uart_tx_data !== cur) stable_ok = 1'b0;
                if (c == due) begin
                    bus.uart_tx_done = 1'b1;
                    pend = 1'b0;
                    last_ack = c;
                end
            end
            if (bus.uart_tx_en === 1'b1) begin
                if (nb < 8) begin
                    got[nb]    = bus.uart_tx_data;
                    en_cyc[nb] = c;
                end
                cur = bus.uart_tx_data;
                nb++;
                if (nb <= ack_limit) begin
                    pend = 1'b1;
                    due  = c + DLY;
                end
            end
            if (bus.report_done === 1'b1)    done_at = c;
            if (bus.report_timeout === 1'b1) to_at = c;
            if ((done_at >= 0 || to_at >= 0) && bus.busy === 1'b0) break;
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] v, input logic err,
                              input logic [4:0][7:0] exp, input int n, input int lat);
        send_req(v, err);
        capture(8, -1, 1000);
        tests++;
        if (nb !== n) begin
            fails++;
            $display("FAIL %s_count: got %0d want %0d", name, nb, n);
        end
        for (int i = 0; i < n && i < nb; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, got[i], exp[i]);
            end
        end
        tests++;
        if (en_cyc[0] !== lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d want %0d", name, en_cyc[0], lat);
        end
        tests++;
        if (nb >= 2 && en_cyc[1] !== en_cyc[0] + DLY + 2) begin
            fails++;
            $display("FAIL %s_gap: got %0d want %0d", name, en_cyc[1], en_cyc[0] + DLY + 2);
        end
        tests++;
        if (done_at < 0 || done_at !== last_ack + 1 || to_at !== -1) begin
            fails++;
            $display("FAIL %s_done: got done@%0d to@%0d want done@%0d", name, done_at, to_at, last_ack + 1);
        end
        tests++;
        if (!stable_ok) begin
            fails++;
            $display("FAIL %s_data_stable: got unstable want stable", name);
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy_end: got %b want 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.uart_tx_en, bus.uart_tx_data, bus.busy, bus.report_done, bus.report_timeout} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b data=%h busy=%b done=%b to=%b want all 0",
                     bus.uart_tx_en, bus.uart_tx_data, bus.busy, bus.report_done, bus.report_timeout);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int extra;
        send_req(8'd42, 1'b0);
        capture(8, 5, 1000);
        tests++;
        if (nb !== 4 || done_at < 0) begin
            fails++;
            $display("FAIL busy_ignore_frame: got %0d bytes done@%0d want 4 bytes and done", nb, done_at);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.uart_tx_en === 1'b1 || bus.busy === 1'b1) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL busy_ignore_queued: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_stray_done();
        int bad;
        @(negedge clk);
        bus.uart_tx_done = 1'b1;
        @(negedge clk);
        bus.uart_tx_done = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.uart_tx_en !== 1'b0 || bus.busy !== 1'b0 || bus.report_done !== 1'b0 ||
                bus.uart_tx_data !== 8'h0A) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stray_done: got %0d disturbed cycles want 0", bad);
        end
    endtask

    task automatic test_timeout();
        send_req(8'd15, 1'b0);
        capture(1, -1, 500);
        tests++;
        if (nb !== 2) begin
            fails++;
            $display("FAIL timeout_bytes: got %0d want 2", nb);
        end
        tests++;
        if (to_at < 0 || to_at !== en_cyc[1] + TO) begin
            fails++;
            $display("FAIL timeout_cycle: got %0d want %0d", to_at, en_cyc[1] + TO);
        end
        tests++;
        if (done_at !== -1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: got done@%0d busy=%b want no done, busy 0", done_at, bus.busy);
        end
        test_frame("after_timeout", 8'd7, 1'b0, {8'h00, 8'h00, 8'h0A, 8'h0D, 8'h37}, 3, 5);
    endtask

    task automatic test_reset_mid();
        int c;
        int extra;
        send_req(8'd15, 1'b0);
        c = 0;
        while (bus.uart_tx_en !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (bus.uart_tx_en !== 1'b1 || bus.uart_tx_data !== 8'h31) begin
            fails++;
            $display("FAIL mid_first_byte: got en=%b data=%h want 1/31", bus.uart_tx_en, bus.uart_tx_data);
        end
        repeat (3) @(negedge clk);
        bus.uart_tx_done = 1'b1;
        @(negedge clk);
        bus.uart_tx_done = 1'b0;
        c = 0;
        while (bus.uart_tx_en !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.uart_tx_en, bus.uart_tx_data, bus.busy, bus.report_done, bus.report_timeout} !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset_outputs: got en=%b data=%h busy=%b want all 0",
                     bus.uart_tx_en, bus.uart_tx_data, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.uart_tx_en === 1'b1 || bus.busy === 1'b1) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL mid_reset_resume: got %0d active cycles want 0", extra);
        end
        test_frame("after_reset", 8'd7, 1'b0, {8'h00, 8'h00, 8'h0A, 8'h0D, 8'h37}, 3, 5);
    endtask

    initial begin
        bus.report_req   = 1'b0;
        bus.report_error = 1'b0;
        bus.param_value  = 8'h00;
        bus.uart_tx_done = 1'b0;
        test_reset();
        test_frame("v42",  8'd42,  1'b0, {8'h00, 8'h0A, 8'h0D, 8'h32, 8'h34}, 4, 9);
        test_frame("v255", 8'd255, 1'b0, {8'h0A, 8'h0D, 8'h35, 8'h35, 8'h32}, 5, 12);
        test_frame("v0",   8'd0,   1'b0, {8'h00, 8'h00, 8'h0A, 8'h0D, 8'h30}, 3, 5);
        test_frame("v100", 8'd100, 1'b0, {8'h0A, 8'h0D, 8'h30, 8'h30, 8'h31}, 5, 6);
        test_frame("err",  8'd99,  1'b1, {8'h0A, 8'h0D, 8'h52, 8'h52, 8'h45}, 5, 2);
        test_busy_ignore();
        test_stray_done();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
